// File: rtl/ppwm_spi_loader_if.sv
// Register-side bus between the SPI loader and the PWM core register file.
// The loader drives strobes, address and write data; the core returns read data.
interface ppwm_spi_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr_en_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [DATA_W-1:0] rdata_i;
  logic              frame_err_o;

  modport master (
    output wr_en_o, rd_en_o, addr_o, wdata_o, frame_err_o,
    input  rdata_i
  );

  modport slave (
    input  wr_en_o, rd_en_o, addr_o, wdata_o, frame_err_o,
    output rdata_i
  );
endinterface

// File: rtl/ppwm_spi_loader.sv
// SPI mode-0 configuration front end: synchronises pad inputs, decodes command/data
// bytes into single-cycle register write/read strobes and shifts read data out on MISO.
module ppwm_spi_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic miso_o,
  ppwm_spi_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, mosi_sy;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   rise, fall, cs_fall, byte_done;

  logic [2:0]             bit_cnt;
  logic [DATA_W-2:0]      sh_in;
  logic [DATA_W-1:0]      miso_sh;
  logic                   skip_fall;

  logic cmd_done, wr_fire, rd_first, rd_next, shift_fire, err_fire;

  // Chains reset to 0 so a chip select already low at reset release never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy <= '0;
      cs_sy   <= '0;
      mosi_sy <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_i};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], cs_n_i};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi_i};
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sy[SYNC_STAGES-1];
  assign cs_s      = cs_sy[SYNC_STAGES-1];
  assign mosi_s    = mosi_sy[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;
  assign byte_done = rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nx = CMD;
        CMD:     if (cs_s) state_nx = IDLE;
                 else if (byte_done) state_nx = sh_in[DATA_W-2] ? WDATA : RDATA;
        WDATA,
        RDATA:   if (cs_s) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The fall that closes the command byte lands in RDATA but must not shift the freshly loaded MSB.
  always_comb begin
    cmd_done   = 1'b0;
    wr_fire    = 1'b0;
    rd_first   = 1'b0;
    rd_next    = 1'b0;
    shift_fire = 1'b0;
    err_fire   = 1'b0;
    if (ena && !cs_s) begin
      cmd_done   = (state == CMD) && byte_done;
      rd_first   = cmd_done && !sh_in[DATA_W-2];
      wr_fire    = (state == WDATA) && byte_done;
      rd_next    = (state == RDATA) && fall && (bit_cnt == 3'd0) && !skip_fall;
      shift_fire = (state == RDATA) && fall && (bit_cnt != 3'd0);
    end
    if (ena && cs_s && (state != IDLE) && (bit_cnt != 3'd0)) err_fire = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt         <= 3'd0;
      sh_in           <= '0;
      miso_sh         <= '0;
      skip_fall       <= 1'b0;
      bus.wr_en_o     <= 1'b0;
      bus.rd_en_o     <= 1'b0;
      bus.addr_o      <= '0;
      bus.wdata_o     <= '0;
      bus.frame_err_o <= 1'b0;
    end else begin
      if (state == IDLE)  bit_cnt <= 3'd0;
      else if (rise)      bit_cnt <= bit_cnt + 3'd1;

      if (rise && (state == CMD || state == WDATA))
        sh_in <= {sh_in[DATA_W-3:0], mosi_s};

      bus.wr_en_o     <= wr_fire;
      bus.rd_en_o     <= rd_first | rd_next;
      bus.frame_err_o <= err_fire;

      if (wr_fire) bus.wdata_o <= {sh_in, mosi_s};

      // Write bursts advance after the strobe; read bursts advance together with the strobe.
      if (cmd_done)
        bus.addr_o <= ADDR_W'({sh_in[DATA_W-3:0], mosi_s});
      else if (bus.wr_en_o || rd_next)
        bus.addr_o <= bus.addr_o + ADDR_W'(1);

      if (cmd_done)
        skip_fall <= 1'b1;
      else if (state == RDATA && fall && bit_cnt == 3'd0)
        skip_fall <= 1'b0;

      if (bus.rd_en_o)     miso_sh <= bus.rdata_i;
      else if (shift_fire) miso_sh <= {miso_sh[DATA_W-2:0], 1'b0};
      else if (state == IDLE) miso_sh <= '0;
    end
  end

  assign miso_o = (state == RDATA) & miso_sh[DATA_W-1];

endmodule

// File: tb/tb_ppwm_spi_loader.sv
// Bench for ppwm_spi_loader: bit-banged SPI frames, scoreboard of expected register strobes.
module tb_ppwm_spi_loader;
  localparam int H = 8;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  ppwm_spi_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ppwm_spi_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi), .miso_o(miso),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  assign bus.rdata_i = mem[bus.addr_o];

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, n_ferr = 0, n_wr = 0, n_rd = 0;

  // Scoreboard: every strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en_o) n_wr++;
      if (bus.rd_en_o) n_rd++;
      if (bus.frame_err_o) n_ferr++;
      if (bus.wr_en_o || bus.rd_en_o) begin
        n_cmp++;
        if (bus.wr_en_o && bus.rd_en_o) begin
          n_bad++;
          $display("FAIL both_strobes: wr=1 rd=1 at %0t, required never together", $time);
        end else if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: wr=%b rd=%b addr=%0d wdata=%02h, required no strobe",
                   bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.wdata_o);
        end else begin
          e = sb.pop_front();
          if (e.is_wr !== bus.wr_en_o || e.addr !== bus.addr_o ||
              (e.is_wr && e.data !== bus.wdata_o)) begin
            n_bad++;
            $display("FAIL strobe: got wr=%b addr=%0d data=%02h, required wr=%b addr=%0d data=%02h",
                     bus.wr_en_o, bus.addr_o, bus.wdata_o, e.is_wr, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] so);
    so = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = b[i];
      clks(H);
      so[i] = miso;
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    clks(H);
  endtask

  task automatic cs_high();
    clks(H);
    cs_n = 1'b1;
    clks(4 * H);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    exp_t x;
    x.is_wr = 1'b1; x.addr = a; x.data = d;
    sb.push_back(x);
  endtask

  task automatic push_rd(input logic [3:0] a);
    exp_t x;
    x.is_wr = 1'b0; x.addr = a; x.data = '0;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing: %0d strobes outstanding, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    logic [7:0] so;
    clks(3);
    n_cmp++;
    if ({miso, bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.wdata_o, bus.frame_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: miso=%b wr=%b rd=%b addr=%0d wdata=%02h err=%b, required all 0",
               miso, bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.wdata_o, bus.frame_err_o);
    end
    rst_n = 1'b1;
    clks(5);
    n_cmp++;
    if ({miso, bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.frame_err_o} !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle: miso=%b wr=%b rd=%b addr=%0d err=%b, required all 0",
               miso, bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.frame_err_o);
    end
    so = '0;
  endtask

  task automatic test_write();
    logic [7:0] so;
    int ferr0 = n_ferr;
    int wr0 = n_wr;
    push_wr(4'd3, 8'h5A);
    cs_low();
    spi_bits(8'h83, 8, so);
    spi_bits(8'h5A, 8, so);
    cs_high();
    drain("write");
    n_cmp++;
    if (n_wr - wr0 != 1 || n_ferr != ferr0) begin
      n_bad++;
      $display("FAIL write_counts: writes=%0d errs=%0d, required 1 and 0", n_wr - wr0, n_ferr - ferr0);
    end
  endtask

  task automatic test_burst();
    logic [7:0] so;
    int wr0 = n_wr;
    push_wr(4'd15, 8'h11);
    push_wr(4'd0, 8'h22);
    cs_low();
    spi_bits(8'h8F, 8, so);
    spi_bits(8'h11, 8, so);
    spi_bits(8'h22, 8, so);
    cs_high();
    drain("burst");
    n_cmp++;
    if (n_wr - wr0 != 2) begin
      n_bad++;
      $display("FAIL burst_count: writes=%0d, required 2", n_wr - wr0);
    end
  endtask

  task automatic test_read();
    logic [7:0] so;
    logic [7:0] want;
    want = 8'hC3;
    mem[2] = want;
    mem[3] = 8'h00;
    push_rd(4'd2);
    push_rd(4'd3);  // burst reload after the 8th data fall
    n_cmp++;
    if (miso !== 1'b0) begin
      n_bad++;
      $display("FAIL miso_idle: miso=%b, required 0", miso);
    end
    cs_low();
    spi_bits(8'h02, 8, so);
    spi_bits(8'h00, 8, so);
    n_cmp++;
    if (so !== want) begin
      n_bad++;
      $display("FAIL read_miso: got %02h, required %02h", so, want);
    end
    cs_high();
    drain("read");
    n_cmp++;
    if (miso !== 1'b0) begin
      n_bad++;
      $display("FAIL miso_after_read: miso=%b, required 0", miso);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] so;
    int ferr0 = n_ferr;
    int wr0 = n_wr;
    cs_low();
    spi_bits(8'h86, 8, so);
    spi_bits(8'hA5, 5, so);
    cs_high();
    n_cmp++;
    if (n_ferr - ferr0 != 1 || n_wr != wr0) begin
      n_bad++;
      $display("FAIL frame_err: errs=%0d writes=%0d, required 1 and 0", n_ferr - ferr0, n_wr - wr0);
    end
    push_wr(4'd1, 8'hFF);
    cs_low();
    spi_bits(8'h81, 8, so);
    spi_bits(8'hFF, 8, so);
    cs_high();
    drain("after_err");
    n_cmp++;
    if (n_ferr - ferr0 != 1) begin
      n_bad++;
      $display("FAIL clean_end_err: errs=%0d, required 1", n_ferr - ferr0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] so;
    int ferr0 = n_ferr;
    int wr0 = n_wr;
    cs_low();
    spi_bits(8'h85, 8, so);
    spi_bits(8'hF0, 3, so);
    mosi = 1'b1;
    clks(H);
    sclk = 1'b1;
    clks(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({miso, bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.wdata_o, bus.frame_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: wr=%b rd=%b addr=%0d wdata=%02h err=%b, required all 0",
               bus.wr_en_o, bus.rd_en_o, bus.addr_o, bus.wdata_o, bus.frame_err_o);
    end
    clks(3);
    rst_n = 1'b1;
    clks(H - 5);
    sclk = 1'b0;
    spi_bits(8'h0F, 4, so);
    spi_bits(8'h77, 8, so);
    cs_high();
    n_cmp++;
    if (n_wr != wr0 || n_ferr != ferr0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: writes=%0d errs=%0d, required 0 and 0", n_wr - wr0, n_ferr - ferr0);
    end
    push_wr(4'd4, 8'h3C);
    cs_low();
    spi_bits(8'h84, 8, so);
    spi_bits(8'h3C, 8, so);
    cs_high();
    drain("reset_mid_recover");
  endtask

  task automatic test_ena();
    logic [7:0] so;
    int ferr0 = n_ferr;
    int wr0 = n_wr;
    ena = 1'b0;
    cs_low();
    spi_bits(8'h87, 8, so);
    spi_bits(8'h99, 8, so);
    cs_high();
    n_cmp++;
    if (n_wr != wr0 || n_ferr != ferr0) begin
      n_bad++;
      $display("FAIL ena_low: writes=%0d errs=%0d, required 0 and 0", n_wr - wr0, n_ferr - ferr0);
    end
    ena = 1'b1;
    clks(4);
    push_wr(4'd7, 8'h99);
    cs_low();
    spi_bits(8'h87, 8, so);
    spi_bits(8'h99, 8, so);
    cs_high();
    drain("ena_high");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    test_reset();
    test_write();
    test_burst();
    test_read();
    test_frame_err();
    test_reset_mid();
    test_ena();
    clks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ppwm_spi_loader.md
Name: ppwm_spi_loader

Overview:
- Serial configuration front end feeding the PWM tile's register file; sits directly upstream of the PWM core inside the tile.
- Receives SPI mode-0 frames on raw pad inputs (taken from ui_in bits), synchronises them to clk, decodes command and data bytes, and issues single-cycle register write/read strobes to the core.
- Returns read data on MISO for bench and silicon readback.

Parameters:
- ADDR_W, 4, register address width; the low ADDR_W bits of the command address field are used, upper bits are ignored.
- DATA_W, 8, register data width; fixed to 8 for byte frames, other values unsupported.
- SYNC_STAGES, 2, flip-flop depth of the pad input synchronisers; minimum 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, tile enable; while low the block is held in IDLE.
- sclk_i, input, 1, raw SPI clock from pad, asynchronous to clk.
- cs_n_i, input, 1, raw SPI chip select from pad, active low.
- mosi_i, input, 1, raw SPI data in.
- miso_o, output, 1, SPI data out.
- wr_en_o, output, 1, one-cycle register write strobe.
- rd_en_o, output, 1, one-cycle register read strobe.
- addr_o, output, ADDR_W, register address for the write or read.
- wdata_o, output, 8, write data, valid while wr_en_o is high.
- rdata_i, input, 8, read data from the core; sampled in the cycle rd_en_o is high.
- frame_err_o, output, 1, one-cycle pulse when a frame ends mid-byte.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active low.
- Reset values: all outputs 0; state IDLE; bit counter 0; shift registers 0.
- Synchronisation: sclk_i, cs_n_i and mosi_i each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk against a one-flop delayed copy. clk must be at least 4x sclk.
- SPI mode 0, MSB first: mosi is sampled on a detected sclk rise; miso updates on a detected sclk fall.
- Bit counter: 3 bits, counts sclk rises, wraps at 8.
- States:
  - IDLE: entered on reset or when ena=0; go to CMD on synchronised cs_n=0 while ena=1.
  - CMD: collect 8 bits. Command bit7 = 1 means write, 0 means read; bits[6:0] give the address. On the 8th bit: latch addr_o and go to WDATA (write) or RDATA (read).
  - WDATA: each completed byte causes wdata_o and wr_en_o=1 for exactly one clk, in the cycle after the 8th rise is detected. Then addr_o increments modulo 2^ADDR_W, ready for the next byte (burst).
  - RDATA: in the cycle after command completion, rd_en_o=1 for one clk. The next cycle loads rdata_i into the 8-bit output shift register, and miso_o presents its MSB. Each detected sclk fall shifts the register left. After 8 falls, addr_o increments (wrapping), rd_en_o pulses, and a reload follows, giving burst reads.
  - Any state goes to IDLE when synchronised cs_n=1.
- Burst write latency: 1 clk from synchronised 8th rise to wr_en_o.
- Read turnaround: rd_en_o and the reload must finish before the first data sclk fall, which the 4x clock ratio guarantees.
- cs_n rising with bit counter != 0: partial byte discarded, no strobe, frame_err_o pulses for 1 clk. cs_n rising with counter = 0 is a clean end with no error.
- miso_o is 0 whenever the state is not RDATA.
- ena falling mid-frame: immediate return to IDLE, no strobe, no frame_err. The block restarts only after cs_n goes high and then low again.
- rst_n asserted mid-frame: all outputs 0 asynchronously. After release, the block waits in IDLE for a fresh cs_n falling edge; a cs_n already low is ignored until it has been high.
- wr_en_o and rd_en_o are never high in the same cycle.

Test Plan:
- Reset then a write frame, command 0x83, data 0x5A -> one wr_en_o pulse with addr_o=3 and wdata_o=0x5A; no other strobes; frame_err_o stays 0.
- Burst write, command 0x8F, data 0x11 0x22 -> writes 0x11 to addr 15, then 0x22 to addr 0 (wrap); exactly 2 pulses.
- Read, command 0x02, core returns rdata_i=0xC3 at addr 2 -> rd_en_o pulse with addr_o=2; miso bits 1,1,0,0,0,0,1,1 on successive sclk rises.
- Write frame where cs_n rises after 5 data bits -> no wr_en_o; frame_err_o pulses once; the next clean frame, command 0x81 data 0xFF, writes correctly.
- rst_n pulsed low during the 4th data bit with cs_n held low -> outputs 0 immediately; no strobe until cs_n toggles high then low and a full frame arrives.
- ena=0 during a full write frame -> no strobes; with ena=1 the same frame produces a write.
